nios_system_mem_tester: RTL and testbench
=========================================

NIOS_SYSTEM_MEM_TESTER -- requirements
Module: nios_system_mem_tester

Interface
REQ-001 SHALL provide parameter ADDR_W, default 15, word-address width of the target memory.
REQ-002 SHALL provide parameter DEPTH, default 32768, number of 32-bit words in the target; addresses wrap modulo DEPTH.
REQ-003 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle command strobe.
REQ-006 SHALL have port mode  in  2  00 fill, 01 check, 10 fill-then-check, 11 reserved.
REQ-007 SHALL have port base  in  ADDR_W  first word address.
REQ-008 SHALL have port count  in  ADDR_W+1  number of words, 0..DEPTH.
REQ-009 SHALL have port seed  in  32  pattern seed.
REQ-010 SHALL have ports address (out, ADDR_W), byteenable (out, 4), chipselect (out, 1), write (out, 1), writedata (out, 32), clken (out, 1), and readdata (in, 32); together these form the Avalon-MM master to a single-port RAM with fixed read latency 1.
REQ-011 SHALL have status ports busy (out 1), done (out 1, one-cycle pulse), error (out 1, sticky), err_count (out 16), first_err_addr (out ADDR_W), first_err_data (out 32).

Function
REQ-012 SHALL compute the expected/written data for word index i as seed + i, modulo 2^32, and use address (base + i) mod DEPTH.
REQ-013 SHALL implement the FSM states IDLE, WRITE, READ, DRAIN, DONE.
REQ-014 SHALL accept start only in IDLE; start while busy, or with mode 11, SHALL be ignored.
REQ-015 SHALL, on acceptance, capture base, count, seed and mode, and clear error, err_count, first_err_addr and first_err_data.
REQ-016 SHALL, with count=0, go IDLE->DONE, perform no bus access, and pulse done one cycle after start.
REQ-017 SHALL, in WRITE, drive chipselect=1, write=1, byteenable=4'hF for one word per cycle, with no gaps.
REQ-018 SHALL, in READ, drive chipselect=1, write=0, byteenable=4'hF for one read per cycle, comparing readdata one cycle after each address against the delayed expected value.
REQ-019 SHALL use DRAIN as one cycle to compare the last read word.
REQ-020 SHALL provide the following timing for start accepted at cycle 0 with count N.
  - Fill: writes at cycles 1..N; done at N+1.
  - Check: reads at cycles 1..N; done at N+2.
  - Fill-then-check: writes at 1..N; reads at N+1..2N; done at 2N+2.
REQ-021 SHALL, on a mismatch, set error and increment err_count, saturating at 16'hFFFF.
REQ-022 SHALL hold busy=1 from the cycle after acceptance through the done cycle, inclusive.
REQ-023 SHALL hold chipselect=0 and write=0 outside WRITE/READ; address and writedata are don't-care there.
REQ-024 SHALL drive clken=1 at all times except during reset.
REQ-025 SHALL return from DONE to IDLE after one cycle; a start in that DONE cycle SHALL be ignored.
REQ-026 SHALL wrap the address DEPTH-1 -> 0 with no extra cycle.

Reset
REQ-027 SHALL, while reset=1, set the FSM to IDLE, with chipselect, write, busy, done, error, err_count, first_err_addr, first_err_data and clken all 0, and address 0.
REQ-028 SHALL treat reset mid-operation as an abort: bus activity stops in the cycle after reset is sampled, no done pulse occurs, and no partial status is retained.

Configuration
REQ-029 SHALL use macro MEM_TESTER_FIRST_ERR_EN to control first-error capture.
  - Defined: the first mismatch after start latches first_err_addr (word address) and the received first_err_data, which hold until the next accepted start or reset.
  - Undefined: first_err_addr and first_err_data are constant 0, with no capture registers.

Verification
REQ-030 SHALL cover fill: base=0x0010, count=4, seed=0xA0000000 -> writes 0xA0000000..0xA0000003 to 0x0010..0x0013 in cycles 1..4; done at cycle 5; error=0.
REQ-031 SHALL cover check with a clean memory: mode=01 after REQ-030 fill -> 4 reads; done at cycle 6; err_count=0.
REQ-032 SHALL cover check with a corrupted word: model returns 0xDEADBEEF at 0x0012 -> error=1, err_count=1; with macro defined, first_err_addr=0x0012 and first_err_data=0xDEADBEEF; undefined -> both 0.
REQ-033 SHALL cover wrap: base=0x7FFE, count=4, mode=10 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; done at cycle 10.
REQ-034 SHALL cover ignored and degenerate commands: count=0 -> done at cycle 1 with no chipselect; start during busy and mode=11 -> ignored.
REQ-035 SHALL cover abort: reset asserted at cycle 3 of count=8 fill -> chipselect=0 from the next cycle, busy=0, no done pulse.

Source files
------------

// File: rtl/nios_system_mem_tester.sv
// rtl/nios_system_mem_tester.sv - fill/check memory tester driving an Avalon-MM single-port RAM (read latency 1).
// Optional first-error capture: define MEM_TESTER_FIRST_ERR_EN.
module nios_system_mem_tester #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic [31:0]       seed,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              clken,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [31:0]       first_err_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       seed_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              cmp_valid;
  logic [31:0]       cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic              error_q;
  logic [15:0]       err_cnt_q;

  logic accept;
  logic last;
  logic mismatch;
  logic [ADDR_W-1:0] addr_next;

  assign accept    = (state == S_IDLE) && start && (mode != 2'b11);
  assign last      = (idx == count_q - 1'b1);
  assign mismatch  = cmp_valid && (readdata != cmp_exp);
  assign addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= 2'b00;
      base_q    <= '0;
      count_q   <= '0;
      seed_q    <= '0;
      idx       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      // Read data returns one cycle after the address, so the expectation rides one stage behind.
      cmp_valid <= (state == S_READ);
      cmp_exp   <= data_q;
      cmp_addr  <= addr_q;

      if (mismatch) begin
        error_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            mode_q    <= mode;
            base_q    <= base;
            count_q   <= count;
            seed_q    <= seed;
            idx       <= '0;
            addr_q    <= base;
            data_q    <= seed;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            if (count == '0)          state <= S_DONE;
            else if (mode == 2'b01)   state <= S_READ;
            else                      state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (last) begin
            if (mode_q == 2'b10) begin
              state  <= S_READ;
              idx    <= '0;
              addr_q <= base_q;
              data_q <= seed_q;
            end else begin
              state <= S_DONE;
            end
          end else begin
            idx    <= idx + 1'b1;
            addr_q <= addr_next;
            data_q <= data_q + 32'd1;
          end
        end
        S_READ: begin
          if (last) begin
            state <= S_DRAIN;
          end else begin
            idx    <= idx + 1'b1;
            addr_q <= addr_next;
            data_q <= data_q + 32'd1;
          end
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_TESTER_FIRST_ERR_EN
  logic [ADDR_W-1:0] fe_addr_q;
  logic [31:0]       fe_data_q;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      fe_addr_q <= '0;
      fe_data_q <= '0;
    end else if (mismatch && !error_q) begin
      fe_addr_q <= cmp_addr;
      fe_data_q <= readdata;
    end
  end

  assign first_err_addr = fe_addr_q;
  assign first_err_data = fe_data_q;
`else
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

  assign chipselect = (state == S_WRITE) || (state == S_READ);
  assign write      = (state == S_WRITE);
  assign byteenable = 4'hF;
  assign address    = addr_q;
  assign writedata  = data_q;
  assign clken      = ~reset;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign error      = error_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_nios_system_mem_tester.sv
// tb/tb_nios_system_mem_tester.sv - randomized self-checking bench for nios_system_mem_tester.
module tb_nios_system_mem_tester;
  localparam int AW    = 15;
  localparam int DEPTH = 32768;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] base = '0;
  logic [AW:0]   count = '0;
  logic [31:0]   seed = '0;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          write;
  logic [31:0]   writedata;
  logic          clken;
  logic [31:0]   readdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;
  logic [31:0]   first_err_data;

  nios_system_mem_tester #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base(base), .count(count),
    .seed(seed), .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .clken(clken), .readdata(readdata),
    .busy(busy), .done(done), .error(error), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read latency 1; flagged words read back as 0xDEADBEEF.
  logic [31:0] ram     [DEPTH] = '{default: 32'h0};
  logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};
  bit          corrupt [DEPTH] = '{default: 1'b0};
  logic [31:0] rd_q = '0;

  always @(posedge clk) begin
    if (chipselect && clken) begin
      if (write) ram[address] <= writedata;
      else       rd_q <= corrupt[address] ? 32'hDEADBEEF : ram[address];
    end
  end
  assign readdata = rd_q;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic cs, input logic wr, input logic [3:0] be,
                                     input logic [AW-1:0] a, input logic [31:0] d);
    return {11'b0, cs, wr, be, a, d};
  endfunction

  function automatic logic [63:0] bus_obs();
    if (!chipselect) return pk(1'b0, write, 4'h0, '0, 32'h0);
    return pk(1'b1, write, byteenable, address, write ? writedata : 32'h0);
  endfunction

  // Expected bus activity in cycle k after acceptance, straight from the command timing rules.
  function automatic logic [63:0] bus_exp(input int k, input int m, input int b, input int n,
                                          input logic [31:0] s);
    int i;
    bit wr_acc, rd_acc;
    wr_acc = 0; rd_acc = 0; i = 0;
    if (m == 0 && k >= 1 && k <= n) begin wr_acc = 1; i = k - 1; end
    if (m == 1 && k >= 1 && k <= n) begin rd_acc = 1; i = k - 1; end
    if (m == 2 && k >= 1 && k <= n) begin wr_acc = 1; i = k - 1; end
    if (m == 2 && k > n && k <= 2 * n) begin rd_acc = 1; i = k - n - 1; end
    if (wr_acc) return pk(1'b1, 1'b1, 4'hF, AW'((b + i) % DEPTH), s + 32'(i));
    if (rd_acc) return pk(1'b1, 1'b0, 4'hF, AW'((b + i) % DEPTH), 32'h0);
    return pk(1'b0, 1'b0, 4'h0, '0, 32'h0);
  endfunction

  task automatic run_cmd(input int m, input int b, input int n, input logic [31:0] s, input bit poke);
    int dc, exp_err, a;
    logic [31:0] got, fd;
    int fa;
    dc = (n == 0) ? 1 : (m == 0) ? n + 1 : (m == 1) ? n + 2 : 2 * n + 2;
    if (m != 1) for (int i = 0; i < n; i++) ref_mem[(b + i) % DEPTH] = s + 32'(i);
    exp_err = 0; fa = 0; fd = 32'h0;
    if (m != 0) begin
      for (int i = 0; i < n; i++) begin
        a = (b + i) % DEPTH;
        got = corrupt[a] ? 32'hDEADBEEF : ref_mem[a];
        if (got != s + 32'(i)) begin
          if (exp_err == 0) begin fa = a; fd = got; end
          exp_err++;
        end
      end
    end
    @(negedge clk);
    start = 1'b1; mode = 2'(m); base = AW'(b); count = (AW+1)'(n); seed = s;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= dc + 1; k++) begin
      check($sformatf("bus m%0d k%0d", m, k), bus_obs(), bus_exp(k, m, b, n, s));
      check($sformatf("done k%0d", k), 64'(done), 64'(k == dc));
      check($sformatf("busy k%0d", k), 64'(busy), 64'(k <= dc));
      if (k == dc) begin
        check("error", 64'(error), 64'(exp_err != 0));
        check("err_count", 64'(err_count), 64'((exp_err > 65535) ? 65535 : exp_err));
`ifdef MEM_TESTER_FIRST_ERR_EN
        check("first_err_addr", 64'(first_err_addr), 64'(fa));
        check("first_err_data", 64'(first_err_data), 64'(fd));
`else
        check("first_err_addr", 64'(first_err_addr), 64'(0));
        check("first_err_data", 64'(first_err_data), 64'(0));
`endif
      end
      // Pokes land while busy and in the done cycle; both must be ignored.
      start = poke && ((k == 2 && k < dc) || k == dc);
      mode = 2'b01; count = (AW+1)'(3); base = AW'(b + 5);
      @(negedge clk);
    end
    start = 1'b0;
    check("idle_after", {62'b0, busy, chipselect}, 64'h0);
  endtask

  initial begin
    int m, b, n;
    logic [31:0] s;
    int ca;
    bit has_c;

    repeat (3) @(negedge clk);
    check("rst cs/wr", {62'b0, chipselect, write}, 64'h0);
    check("rst busy/done", {62'b0, busy, done}, 64'h0);
    check("rst error/cnt", {47'b0, error, err_count}, 64'h0);
    check("rst first_err", {17'b0, first_err_addr, first_err_data}, 64'h0);
    check("rst clken", 64'(clken), 64'h0);
    check("rst address", 64'(address), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    check("clken run", 64'(clken), 64'h1);

    run_cmd(0, 'h0010, 4, 32'hA0000000, 0);
    run_cmd(1, 'h0010, 4, 32'hA0000000, 0);
    corrupt['h0012] = 1'b1;
    run_cmd(1, 'h0010, 4, 32'hA0000000, 0);
    corrupt['h0012] = 1'b0;
    run_cmd(2, 'h7FFE, 4, 32'h12345678, 1);
    run_cmd(0, 'h0005, 0, 32'h0, 1);
    run_cmd(2, 'h0040, 1, 32'hFFFFFFFF, 1);

    // Reserved mode is ignored.
    @(negedge clk);
    start = 1'b1; mode = 2'b11; count = (AW+1)'(4); base = AW'('h20);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("mode11 k%0d", k), {61'b0, chipselect, busy, done}, 64'h0);
      @(negedge clk);
    end

    // Abort: reset sampled at the end of cycle 3 of an 8-word fill.
    start = 1'b1; mode = 2'b00; base = AW'('h100); count = (AW+1)'(8); seed = 32'h55550000;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("abort bus k%0d", k), bus_obs(), bus_exp(k, 0, 'h100, 8, 32'h55550000));
      if (k == 3) reset = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) ref_mem['h100 + i] = 32'h55550000 + 32'(i);
    check("abort cs/busy/done", {61'b0, chipselect, busy, done}, 64'h0);
    check("abort clken", 64'(clken), 64'h0);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("abort quiet %0d", k), {60'b0, chipselect, busy, done, error}, 64'h0);
    end

    for (int t = 0; t < 30; t++) begin
      m = $urandom_range(0, 2);
      b = $urandom_range(0, DEPTH - 1);
      if (t % 5 == 0) b = DEPTH - $urandom_range(1, 4);
      n = $urandom_range(0, 10);
      s = $urandom;
      has_c = (m != 0) && (n > 0) && ($urandom_range(0, 1) == 1);
      ca = has_c ? (b + $urandom_range(0, n - 1)) % DEPTH : 0;
      if (has_c) corrupt[ca] = 1'b1;
      run_cmd(m, b, n, s, $urandom_range(0, 1) == 1);
      if (has_c) corrupt[ca] = 1'b0;
      // Re-check the just-written region so clean reads are also exercised.
      if (m == 0 && n > 0) run_cmd(1, b, n, s, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
